// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver (16 ticks/bit) feeding a first-word-fall-through FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of ticks 7/8/9.
module uart_rx_buffered #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            rx_i,
  input  logic [15:0]                     cfg_div_i,
  input  logic                            cfg_en_i,
  input  logic                            cfg_parity_en_i,
  input  logic                            cfg_parity_odd_i,
  input  logic [1:0]                      cfg_bits_i,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_perr_o,
  output logic                            rx_ferr_o,
  output logic                            rx_brk_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt_o,
  output logic                            overrun_o,
  input  logic                            err_clr_i,
  output logic                            busy_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [15:0]            div_q, div_d;
  logic [3:0]             tick_q, tick_d;
  logic [1:0]             samp_q, samp_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             data_q, data_d;
  logic                   par_q, par_d;
  logic                   push_q, push_d;
  logic [10:0]            entry_q, entry_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovr_q, ovr_d;
  logic [10:0]            mem_q [FIFO_DEPTH];

  logic rx_s, fall, tick, s9, s15, bit_val, last_bit, exp_par, ferr;
  logic valid, full, pop, acc;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tick_d    = tick_q;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    push_d    = 1'b0;
    entry_d   = entry_q;
    sync_d    = cfg_en_i ? {sync_q[SYNC_STAGES-2:0], rx_i} : '1;
    rx_prev_d = cfg_en_i ? rx_s : 1'b1;

    fall     = rx_prev_q & ~rx_s;
    tick     = (state_q != IDLE) && (div_q == cfg_div_i);
    s9       = tick && (tick_q == 4'd9);
    s15      = tick && (tick_q == 4'd15);
    last_bit = (bit_idx_q == ({1'b0, cfg_bits_i} + 3'd4));
    exp_par  = (^data_q) ^ cfg_parity_odd_i;
`ifdef UART_RX_MAJORITY_EN
    // samp_q holds ticks 7 and 8; the live sample is tick 9
    bit_val  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
`else
    bit_val  = samp_q[1];
`endif
    ferr     = ~bit_val;

    if (state_q != IDLE) begin
      div_d = tick ? 16'd0 : div_q + 16'd1;
      if (tick) tick_d = tick_q + 4'd1;
      if (tick && tick_q == 4'd7) samp_d[0] = rx_s;
      if (tick && tick_q == 4'd8) samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        div_d  = '0;
        tick_d = '0;
        if (fall) begin
          state_d   = START;
          data_d    = '0;
          bit_idx_d = '0;
          par_d     = 1'b0;
        end
      end
      START: begin
        if (s9 && bit_val) state_d = IDLE;
        else if (s15)      state_d = DATA;
      end
      DATA: begin
        if (s9) data_d[bit_idx_q] = bit_val;
        if (s15) begin
          if (last_bit) state_d = cfg_parity_en_i ? PARITY : STOP;
          else          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (s9)  par_d   = bit_val;
        if (s15) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop-bit decision so a start edge in its second half is caught
        if (s9) begin
          state_d = IDLE;
          push_d  = 1'b1;
          entry_d = {ferr & (data_q == 8'd0) & ~par_q, ferr,
                     cfg_parity_en_i & (par_q != exp_par), data_q};
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_en_i) begin
      state_d = IDLE;
      div_d   = '0;
      tick_d  = '0;
      push_d  = 1'b0;
    end
  end

  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = valid & rx_ready_i;
  assign acc   = push_q & (~full | pop);

  always_comb begin
    wr_d  = wr_q + AW'(acc);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(acc) - CW'(pop);
    ovr_d = (push_q & full & ~pop) | (ovr_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      tick_q    <= '0;
      samp_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      push_q    <= 1'b0;
      entry_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      push_q    <= push_d;
      entry_q   <= entry_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc) mem_q[wr_q] <= entry_q;
  end

  // Head outputs are gated so an empty FIFO always presents zeros
  assign rx_valid_o = valid;
  assign rx_data_o  = valid ? mem_q[rd_q][7:0] : 8'd0;
  assign rx_perr_o  = valid & mem_q[rd_q][8];
  assign rx_ferr_o  = valid & mem_q[rd_q][9];
  assign rx_brk_o   = valid & mem_q[rd_q][10];
  assign fifo_cnt_o = cnt_q;
  assign overrun_o  = ovr_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered (FIFO_DEPTH=4, divider 0 => one tick per clock).
module tb_uart_rx_buffered;
  logic       clk_i = 1'b0;
  logic       rst_i, rx_i, cfg_en_i, cfg_parity_en_i, cfg_parity_odd_i;
  logic [15:0] cfg_div_i;
  logic [1:0] cfg_bits_i;
  logic [7:0] rx_data_o;
  logic       rx_perr_o, rx_ferr_o, rx_brk_o, rx_valid_o, rx_ready_i;
  logic [2:0] fifo_cnt_o;
  logic       overrun_o, err_clr_i, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int valid_r;

  always #5 clk_i = ~clk_i;

  uart_rx_buffered #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .cfg_div_i(cfg_div_i),
    .cfg_en_i(cfg_en_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_parity_odd_i(cfg_parity_odd_i), .cfg_bits_i(cfg_bits_i),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_ferr_o(rx_ferr_o),
    .rx_brk_o(rx_brk_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .fifo_cnt_o(fifo_cnt_o), .overrun_o(overrun_o), .err_clr_i(err_clr_i),
    .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drives one frame, 16 clocks per bit, then 6 idle clocks. gbit inverts data bit gbit
  // for the single clock seen by tick 8; pop_r raises rx_ready_i at that loop index;
  // dis_r drops cfg_en_i at that loop index until the frame ends.
  task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit pval,
                      input bit stopv, input int gbit, input int pop_r, input int dis_r);
    logic ln [0:11];
    int   nt;
    int   k;
    ln[0] = 1'b0;
    for (int i = 0; i < nb; i++) ln[1+i] = d[i];
    nt = 1 + nb;
    if (pen) begin
      ln[nt] = pval;
      nt++;
    end
    ln[nt] = stopv;
    nt++;
    valid_r = -1;
    for (int r = 0; r < 16*nt + 6; r++) begin
      @(negedge clk_i);
      if (rx_valid_o && valid_r < 0) valid_r = r;
      k = r / 16;
      rx_i = (k < nt) ? ln[k] : 1'b1;
      if (gbit >= 0 && r == 16*(gbit+1) + 9) rx_i = ~rx_i;
      rx_ready_i = (r == pop_r);
      if (r == dis_r) cfg_en_i = 1'b0;
    end
    rx_ready_i = 1'b0;
    cfg_en_i   = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  initial begin
    logic [7:0] exp_glitch;
    logic [7:0] exp_q [4];
    rst_i = 1'b1; rx_i = 1'b1; cfg_div_i = 16'd0; cfg_en_i = 1'b1;
    cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0; cfg_bits_i = 2'd3;
    rx_ready_i = 1'b0; err_clr_i = 1'b0;
    #1;
    check("rst_valid", rx_valid_o, 0);
    check("rst_cnt", fifo_cnt_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", rx_data_o, 0);
    idle(3);
    rst_i = 1'b0;
    idle(3);

    // 8N1 0xA5
    send(8'hA5, 8, 0, 0, 1, -1, -1, -1);
    check("a5_latency_ok", (valid_r >= 150 && valid_r <= 170), 1);
    check("a5_data", rx_data_o, 8'hA5);
    check("a5_flags", {rx_brk_o, rx_ferr_o, rx_perr_o}, 0);
    check("a5_cnt", fifo_cnt_o, 1);
    pop_one();
    check("a5_pop_cnt", fifo_cnt_o, 0);
    check("a5_pop_valid", rx_valid_o, 0);

    // 7-bit even parity with wrong parity bit (0x3C has four ones -> expected 0)
    cfg_bits_i = 2'd2; cfg_parity_en_i = 1'b1; cfg_parity_odd_i = 1'b0;
    send(8'h3C, 7, 1, 1, 1, -1, -1, -1);
    check("pe_data", rx_data_o, 8'h3C);
    check("pe_perr", rx_perr_o, 1);
    check("pe_ferr_brk", {rx_brk_o, rx_ferr_o}, 0);
    pop_one();
    cfg_parity_odd_i = 1'b1;
    send(8'h3C, 7, 1, 1, 1, -1, -1, -1);
    check("po_data", rx_data_o, 8'h3C);
    check("po_perr", rx_perr_o, 0);
    pop_one();
    cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0;

    // False start: 4-tick low pulse
    for (int r = 0; r < 24; r++) begin
      @(negedge clk_i);
      if (r == 6)  check("fs_busy_hi", busy_o, 1);
      if (r == 19) check("fs_busy_lo", busy_o, 0);
      rx_i = (r < 4) ? 1'b0 : 1'b1;
    end
    check("fs_cnt", fifo_cnt_o, 0);

    // Break: 0x00 with stop bit 0
    send(8'h00, 8, 0, 0, 0, -1, -1, -1);
    check("brk_data", rx_data_o, 8'h00);
    check("brk_flags", {rx_brk_o, rx_ferr_o, rx_perr_o}, 3'b110);
    pop_one();
    idle(10);

    // Glitch data bit 0 of 0x5A at tick 8 only
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h5A;
`else
    exp_glitch = 8'h5B;
`endif
    send(8'h5A, 8, 0, 0, 1, 0, -1, -1);
    check("glitch_data", rx_data_o, exp_glitch);
    pop_one();

    // Disable mid-frame discards it
    send(8'h77, 8, 0, 0, 1, -1, -1, 80);
    idle(4);
    check("dis_cnt", fifo_cnt_o, 0);
    check("dis_busy", busy_o, 0);

    // Reset in the middle of a byte
    for (int r = 0; r < 40; r++) begin
      @(negedge clk_i);
      rx_i = (r < 20) ? 1'b0 : 1'b1;
    end
    check("mid_busy_pre", busy_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy", busy_o, 0);
    idle(2);
    rst_i = 1'b0;
    idle(5);
    send(8'h55, 8, 0, 0, 1, -1, -1, -1);
    check("mid_cnt", fifo_cnt_o, 1);
    check("mid_data", rx_data_o, 8'h55);
    check("mid_flags", {rx_brk_o, rx_ferr_o, rx_perr_o}, 0);
    pop_one();

    // Overrun: five frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 8, 0, 0, 1, -1, -1, -1);
    check("ovr_cnt", fifo_cnt_o, 4);
    check("ovr_set", overrun_o, 1);
    check("ovr_head", rx_data_o, 8'h11);
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    check("ovr_clr", overrun_o, 0);

    // Pop on the exact clock the next frame is pushed while full
    send(8'h16, 8, 0, 0, 1, -1, 157, -1);
    check("pp_ovr", overrun_o, 0);
    check("pp_cnt", fifo_cnt_o, 4);
    exp_q[0] = 8'h12; exp_q[1] = 8'h13; exp_q[2] = 8'h14; exp_q[3] = 8'h16;
    for (int i = 0; i < 4; i++) begin
      check("pp_drain", rx_data_o, exp_q[i]);
      pop_one();
    end
    check("pp_empty", fifo_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
